ha_array_seq_ctrl: RTL and testbench



---
 rtl/ha_array_seq_ctrl.sv | 104 ++++++++++
 tb/tb_ha_array_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ha_array_seq_ctrl.sv
// ha_array_seq_ctrl: sequences operands into the 8x8 HA array and reduces its four rows into a 16-bit product.
// Optional saturating bias compensation on the final row: HA_SEQ_BIAS_COMP_EN.
module ha_array_seq_ctrl #(
  parameter int          ARRAY_LAT = 0,
  parameter logic [15:0] BIAS      = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic [7:0]  mul_x,
  output logic [7:0]  mul_y,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, ACC, DONE} state_t;
  state_t      state_q;
  logic [1:0]  row_q, wait_q;
  logic [15:0] acc_q, out_p_q, term, acc_d, p_d;
  logic [7:0]  mul_x_q, mul_y_q;
  logic        ovf_q, out_ovf_q, ovf_d;
  logic [6:0]  b_sel;
  logic [8:0]  t_sel;
  logic [17:0] sum;
  always_comb begin
    b_sel = row_q == 2'd0 ? ha_array_0_b : row_q == 2'd1 ? ha_array_1_b : row_q == 2'd2 ? ha_array_2_b : ha_array_3_b;
    t_sel = row_q == 2'd0 ? ha_array_0_t : row_q == 2'd1 ? ha_array_1_t : row_q == 2'd2 ? ha_array_2_t : ha_array_3_t;
    term  = (16'(t_sel) + (16'(b_sel) << 2)) << {row_q, 1'b0};
`ifdef HA_SEQ_BIAS_COMP_EN
    sum   = {2'b0, acc_q} + {2'b0, term} + (row_q == 2'd3 ? {2'b0, BIAS} : 18'd0);
    ovf_d = ovf_q | (|sum[17:16]);
    p_d   = ovf_d ? 16'hFFFF : sum[15:0];
`else
    sum   = {2'b0, acc_q} + {2'b0, term};
    ovf_d = ovf_q | (|sum[17:16]);
    p_d   = sum[15:0];
`endif
    acc_d = sum[15:0];
  end
`ifndef HA_SEQ_BIAS_COMP_EN
  logic unused_bias;
  assign unused_bias = ^BIAS;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= 2'd0;
      wait_q    <= 2'd0;
      acc_q     <= 16'd0;
      ovf_q     <= 1'b0;
      mul_x_q   <= 8'd0;
      mul_y_q   <= 8'd0;
      out_p_q   <= 16'd0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          mul_x_q <= in_x;
          mul_y_q <= in_y;
          acc_q   <= 16'd0;
          ovf_q   <= 1'b0;
          row_q   <= 2'd0;
          wait_q  <= 2'(ARRAY_LAT);
          state_q <= ARRAY_LAT > 0 ? WAIT : ACC;
        end
        WAIT: begin
          wait_q <= wait_q - 2'd1;
          if (wait_q == 2'd1) state_q <= ACC;
        end
        ACC: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          row_q <= row_q + 2'd1;
          if (row_q == 2'd3) begin
            out_p_q   <= p_d;
            out_ovf_q <= ovf_d;
            state_q   <= DONE;
          end
        end
        default: if (out_ready) state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_p     = out_p_q;
  assign out_ovf   = out_ovf_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
endmodule

// File: tb/tb_ha_array_seq_ctrl.sv
// tb_ha_array_seq_ctrl: directed checks of the sequencing controller at ARRAY_LAT=0 and ARRAY_LAT=2.
module tb_ha_array_seq_ctrl;
`ifdef HA_SEQ_BIAS_COMP_EN
  localparam logic [15:0] BI = 16'h0010;
`else
  localparam logic [15:0] BI = 16'h0000;
`endif
  logic clk = 0, rst = 1;
  logic iv0 = 0, or0 = 0, iv2 = 0, or2 = 1;
  logic [7:0] in_x = 0, in_y = 0;
  logic [6:0] b0 = 0, b1 = 0, b2 = 0, b3 = 0;
  logic [8:0] t0 = 0, t1 = 0, t2 = 0, t3 = 0;
  logic rdy0, ov0, ovf0, busy0, rdy2, ov2, ovf2, busy2;
  logic [7:0] mx0, my0, mx2, my2;
  logic [15:0] p0, p2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ha_array_seq_ctrl #(.ARRAY_LAT(0), .BIAS(BI)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in_x(in_x), .in_y(in_y),
    .mul_x(mx0), .mul_y(my0),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(ov0), .out_ready(or0), .out_p(p0), .out_ovf(ovf0), .busy(busy0));
  ha_array_seq_ctrl #(.ARRAY_LAT(2), .BIAS(BI)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in_x(in_x), .in_y(in_y),
    .mul_x(mx2), .mul_y(my2),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(ov2), .out_ready(or2), .out_p(p2), .out_ovf(ovf2), .busy(busy2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [16:0] model();
    int s;
    s = t0 + b0 * 4 + (t1 + b1 * 4) * 4 + (t2 + b2 * 4) * 16 + (t3 + b3 * 4) * 64 + int'(BI);
`ifdef HA_SEQ_BIAS_COMP_EN
    if (s > 65535) return {1'b1, 16'hFFFF};
`endif
    return {s > 65535, 16'(s)};
  endfunction
  task automatic vec(input logic [6:0] a0, a1, a2, a3, input logic [8:0] c0, c1, c2, c3);
    b0 = a0; b1 = a1; b2 = a2; b3 = a3;
    t0 = c0; t1 = c1; t2 = c2; t3 = c3;
  endtask
  task automatic go0(input string tg, input logic [7:0] x, y, input logic [15:0] ep, input logic eo, input bit hold);
    int n;
    chk({tg, "_rdy"}, rdy0, 1);
    in_x = x; in_y = y; iv0 = 1;
    @(posedge clk); #1;
    iv0 = 0;
    n = 1;
    while (!ov0 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tg, "_lat"}, n, 5);
    chk({tg, "_p"}, p0, ep);
    chk({tg, "_ovf"}, ovf0, eo);
    chk({tg, "_mx"}, mx0, x);
    chk({tg, "_my"}, my0, y);
    if (hold) begin
      in_x = ~x; in_y = ~y; iv0 = 1;
      for (int i = 0; i < 7; i++) begin
        @(posedge clk); #1;
        chk({tg, "_bp_v"}, ov0, 1);
        chk({tg, "_bp_p"}, p0, ep);
        chk({tg, "_bp_rdy"}, rdy0, 0);
      end
      iv0 = 0;
    end
    or0 = 1;
    @(posedge clk); #1;
    or0 = 0;
    chk({tg, "_drop_v"}, ov0, 0);
    chk({tg, "_rdy_after"}, rdy0, 1);
    chk({tg, "_busy_after"}, busy0, 0);
    chk({tg, "_mx_held"}, mx0, x);
  endtask
  initial begin
    logic [16:0] m;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_rdy", rdy0, 1);
    chk("rst_v", ov0, 0);
    chk("rst_p", p0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_mx", mx0, 0);
    chk("rst_my", my0, 0);
    vec(0, 0, 0, 0, 9'h001, 0, 0, 0);
    go0("one", 8'h03, 8'h05, 16'h0001 + BI, 0, 0);
    vec(0, 0, 0, 7'h40, 0, 0, 0, 0);
    go0("b3", 8'h11, 8'h22, 16'h4000 + BI, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 9'h100);
    go0("t3", 8'h33, 8'h44, 16'h4000 + BI, 0, 0);
    vec(0, 0, 0, 7'h40, 0, 0, 0, 9'h100);
    go0("bt3", 8'h55, 8'h66, 16'h8000 + BI, 0, 0);
    vec(0, 7'h15, 0, 0, 0, 0, 9'h0AB, 0);
    go0("mix", 8'hA5, 8'h5A, 16'h0C00 + BI, 0, 0);
    vec(7'h7F, 7'h7F, 7'h7F, 7'h7F, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
`ifdef HA_SEQ_BIAS_COMP_EN
    go0("ones", 8'hFF, 8'hFF, 16'hFFFF, 1, 0);
`else
    go0("ones", 8'hFF, 8'hFF, 16'h5257, 1, 0);
`endif
    vec(0, 0, 0, 0, 9'h001, 0, 0, 0);
    go0("bp", 8'h12, 8'h34, 16'h0001 + BI, 0, 1);
    vec(0, 7'h15, 0, 0, 0, 0, 9'h0AB, 0);
    in_x = 8'h77; in_y = 8'h88; iv0 = 1;
    @(posedge clk); #1;
    iv0 = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_busy", busy0, 0);
    chk("mid_rdy", rdy0, 1);
    chk("mid_v", ov0, 0);
    chk("mid_p", p0, 0);
    go0("post_rst", 8'h77, 8'h88, 16'h0C00 + BI, 0, 0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) vec(0, 7'h15, 0, 0, 0, 0, 9'h0AB, 0);
      else vec(7'h01, 0, 7'h02, 0, 0, 9'h003, 0, 9'h010);
      m = model();
      chk("l2_model", m, k == 0 ? {1'b0, 16'h0C00 + BI} : {1'b0, 16'h0490 + BI});
      n = 0;
      while (!rdy2 && n < 20) begin @(posedge clk); #1; n++; end
      chk("l2_rdy", rdy2, 1);
      in_x = 8'(k + 1); iv2 = 1;
      @(posedge clk); #1;
      iv2 = 0;
      n = 1;
      while (!ov2 && n < 20) begin @(posedge clk); #1; n++; end
      chk("l2_lat", n, 7);
      chk("l2_p", p2, m[15:0]);
      chk("l2_ovf", ovf2, m[16]);
      chk("l2_mx", mx2, 8'(k + 1));
    end
    @(posedge clk); #1;
    chk("l2_drop", ov2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
